dp_linefmt: RTL and testbench
=============================

Name: dp_linefmt

Overview:
- Single-lane DisplayPort main-link line formatter, directly downstream of the pixel-clock timing generator.
- Consumes the timing generator's dphstart/dpvstart pulses and emits one 9-bit symbol per clock. A symbol is {K flag, byte}.
- Per line it emits the blanking-start header, then fill, then the active-pixel byte stream, which it pulls from the pixel FIFO over a valid/ready handshake.
- Output goes to the scrambler/encoder stage.

Parameters:
- BS_SYM, 9'h1BC, blanking-start control symbol (K28.5).
- BE_SYM, 9'h1FB, blanking-end control symbol (K27.7).
- HDR_LEN, 4, number of header symbols per line (BS, VB-ID, Mvid, Maud).

Ports:
- clk  in  1  symbol clock.
- resetn  in  1  asynchronous, active-low reset.
- dphstart  in  1  line-start pulse from the timing generator.
- dpvstart  in  1  frame-start pulse. Always coincides with a dphstart.
- hact  in  16  active bytes per line.
- vact  in  16  active lines per frame.
- hdata  in  16  symbol position of BE relative to BS.
- mvid  in  8  Mvid[7:0] for the header.
- pxdata  in  8  pixel byte from the FIFO.
- pxvalid  in  1  pxdata valid.
- pxready  out  1  formatter accepts pxdata this cycle.
- sym  out  9  output symbol; bit 8 is the K flag.
- vblank  out  1  current line is inactive.
- underrun  out  1  sticky flag: a pixel was missing.
- clrerr  in  1  clears underrun.

Behaviour:
- Reset (resetn low, async): sym=0, pxready=0, vblank=1, underrun=0, state IDLE, framed=0, yline=0.
- States: IDLE, HDR, FILL1, BE, DATA, FILL2.
- Sym is registered. Let E0 be the rising edge that samples dphstart=1. The symbol for line position p is driven onto sym after edge E0+p.
- Line bookkeeping at E0:
  - If dpvstart=1: yline<=0 and framed<=1.
  - Otherwise: yline<=yline+1, saturating at 16'hFFFF.
  - active = framed_next && (yline_next < vact). vblank <= !active. vblank is held for the whole line.
- Before the first dpvstart (framed=0): dphstart is ignored, the state stays IDLE, and sym=0.
- Let H = max(hdata, HDR_LEN).
- Symbol sequence per line:
  - p=0: BS_SYM.
  - p=1: VB-ID = {1'b0, 7'b0, !active}.
  - p=2: {1'b0, mvid}, with mvid sampled at E0.
  - p=3: 9'h000 (Maud).
  - p=4..H-1: fill, 9'h000.
  - Inactive line: fill (9'h000) from p=4 until the next dphstart. No BE, no DATA.
  - Active line, p=H: BE_SYM.
  - Active line, p=H+1..H+hact: data bytes.
  - Active line, after the last data byte: fill (9'h000) until the next dphstart.
- Handshake:
  - pxready = (state==DATA) && (bytes remaining>0) && !dphstart. It is combinational from registered state.
  - A byte transfers on an edge where pxvalid && pxready.
  - At data position H+k, sym <= {1'b0, pxdata} if the transfer occurs. Otherwise sym <= 9'h000 and underrun <= 1.
  - The byte counter advances every DATA cycle either way, so line length is fixed and never stretches.
  - hact captured at E0 sets the byte count. hact=0: BE is followed directly by fill.
- dphstart in any state (including mid-DATA or mid-header):
  - Aborts the current line and restarts at p=0 on the same edge.
  - Remaining bytes are not fetched and no underrun is flagged for them.
- Position counter: 16 bits, saturating. No wrap back into header states.
- Underrun:
  - Set takes priority over clrerr in the same cycle.
  - Otherwise clrerr=1 clears it on the next edge.
- Config inputs (hact, vact, hdata, mvid) are sampled only at E0. Changes mid-line have no effect until the next line.

Test Plan:
- Reset then idle: dphstart pulses without dpvstart -> sym stays 0, pxready stays 0, vblank=1.
- Active line: vact=2, hact=3, hdata=6, mvid=8'h5A, pxvalid=1, FIFO bytes 11,22,33; pulse dpvstart+dphstart -> sym sequence 1BC,000,05A,000,000,000,1FB,011,022,033, then 000 until the next dphstart; underrun=0.
- Vertical blanking: same config, third dphstart after the dpvstart (yline=2 >= vact) -> 1BC,001,05A,000 then 000; pxready never asserts; vblank=1.
- Underrun: hact=4; pxvalid low for the 2nd byte only -> bytes b0,000,b2,b3 (the 2nd byte position emits 000, so the FIFO's 2nd byte appears as b2); underrun=1 and stays set until clrerr; clrerr in the same cycle as a fresh underrun leaves underrun=1.
- Short hdata / abort: hdata=1, hact=8 -> BE at p=4; dphstart asserted at p=7 -> sym=1BC on that edge, pxready=0 in that cycle, only 2 bytes consumed.
- Async reset mid-DATA: resetn low between edges -> sym=0, pxready=0 immediately; after release, no output until the next dpvstart.

Source files
------------

// File: rtl/dp_linefmt.sv
// DisplayPort single-lane line formatter: emits BS/VB-ID/Mvid/Maud header,
// fill, BE and the active pixel byte stream pulled from the pixel FIFO.
`timescale 1ns/1ps
module dp_linefmt #(
  parameter logic [8:0] BS_SYM  = 9'h1BC,
  parameter logic [8:0] BE_SYM  = 9'h1FB,
  parameter int         HDR_LEN = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dphstart,
  input  logic        dpvstart,
  input  logic [15:0] hact,
  input  logic [15:0] vact,
  input  logic [15:0] hdata,
  input  logic [7:0]  mvid,
  input  logic [7:0]  pxdata,
  input  logic        pxvalid,
  output logic        pxready,
  output logic [8:0]  sym,
  output logic        vblank,
  output logic        underrun,
  input  logic        clrerr
);

  // state | meaning (phase of the NEXT symbol to be driven)
  // IDLE  | no frame seen yet, sym held at 0
  // HDR   | header positions 1..HDR_LEN-1
  // FILL1 | fill between header and BE
  // BE    | blanking-end symbol
  // DATA  | active pixel bytes
  // FILL2 | fill until next line start
  typedef enum logic [2:0] {IDLE, HDR, FILL1, BE, DATA, FILL2} state_t;

  localparam logic [15:0] HDR_LEN16 = 16'(HDR_LEN);

  state_t      r_state;
  logic [15:0] r_pos;
  logic [15:0] r_yline;
  logic [15:0] r_h;
  logic [15:0] r_rem;
  logic [7:0]  r_mvid;
  logic        r_framed;
  logic        r_active;
  logic [8:0]  r_sym;
  logic        r_vblank;
  logic        r_underrun;

  logic        w_start;
  logic        w_framed_nx;
  logic [15:0] w_yline_nx;
  logic        w_active_nx;
  logic [15:0] w_h;
  logic [15:0] w_pos_inc;
  logic        w_data_slot;
  logic        w_xfer;
  logic        w_miss;

  // dphstart only counts once a frame start has been seen
  assign w_start     = dphstart && (r_framed || dpvstart);
  assign w_framed_nx = r_framed || dpvstart;
  assign w_yline_nx  = dpvstart ? 16'd0 :
                       ((r_yline == 16'hFFFF) ? 16'hFFFF : r_yline + 16'd1);
  assign w_active_nx = w_framed_nx && (w_yline_nx < vact);
  assign w_h         = (hdata < HDR_LEN16) ? HDR_LEN16 : hdata;
  assign w_pos_inc   = (r_pos == 16'hFFFF) ? r_pos : r_pos + 16'd1;

  assign w_data_slot = (r_state == DATA) && (r_rem != 16'd0) && !dphstart;
  assign pxready     = w_data_slot;
  assign w_xfer      = w_data_slot && pxvalid;
  assign w_miss      = w_data_slot && !pxvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_pos      <= 16'd0;
      r_yline    <= 16'd0;
      r_h        <= HDR_LEN16;
      r_rem      <= 16'd0;
      r_mvid     <= 8'd0;
      r_framed   <= 1'b0;
      r_active   <= 1'b0;
      r_sym      <= 9'h000;
      r_vblank   <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      if (w_start) begin
        r_framed <= w_framed_nx;
        r_yline  <= w_yline_nx;
        r_active <= w_active_nx;
        r_vblank <= !w_active_nx;
        r_h      <= w_h;
        r_rem    <= hact;
        r_mvid   <= mvid;
        r_sym    <= BS_SYM;
        r_pos    <= 16'd1;
        r_state  <= HDR;
      end else begin
        case (r_state)
          IDLE: begin
            r_sym <= 9'h000;
          end
          HDR: begin
            if (r_pos == 16'd1)      r_sym <= {8'b0, !r_active};
            else if (r_pos == 16'd2) r_sym <= {1'b0, r_mvid};
            else                     r_sym <= 9'h000;
            r_pos <= w_pos_inc;
            if (r_pos == HDR_LEN16 - 16'd1) begin
              if (!r_active)              r_state <= FILL2;
              else if (r_h == HDR_LEN16)  r_state <= BE;
              else                        r_state <= FILL1;
            end
          end
          FILL1: begin
            r_sym <= 9'h000;
            r_pos <= w_pos_inc;
            if (r_pos == r_h - 16'd1) r_state <= BE;
          end
          BE: begin
            r_sym   <= BE_SYM;
            r_pos   <= w_pos_inc;
            r_state <= (r_rem != 16'd0) ? DATA : FILL2;
          end
          DATA: begin
            r_sym <= w_xfer ? {1'b0, pxdata} : 9'h000;
            r_pos <= w_pos_inc;
            if (r_rem != 16'd0) r_rem <= r_rem - 16'd1;
            if (r_rem <= 16'd1) r_state <= FILL2;
          end
          FILL2: begin
            r_sym <= 9'h000;
            r_pos <= w_pos_inc;
          end
          default: begin
            r_sym   <= 9'h000;
            r_state <= IDLE;
          end
        endcase
      end

      if (w_miss)      r_underrun <= 1'b1;
      else if (clrerr) r_underrun <= 1'b0;
    end
  end

  assign sym      = r_sym;
  assign vblank   = r_vblank;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_dp_linefmt.sv
// Directed bench for dp_linefmt: line sequences, blanking, underrun,
// line abort and async reset, against hand-computed symbol tables.
`timescale 1ns/1ps
module tb_dp_linefmt;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        dphstart = 1'b0;
  logic        dpvstart = 1'b0;
  logic [15:0] hact = '0;
  logic [15:0] vact = '0;
  logic [15:0] hdata = '0;
  logic [7:0]  mvid = '0;
  logic [7:0]  pxdata;
  logic        pxvalid = 1'b0;
  logic        pxready;
  logic [8:0]  sym;
  logic        vblank;
  logic        underrun;
  logic        clrerr = 1'b0;

  logic [7:0]  fifo_mem [0:15];
  int          fifo_idx = 0;
  logic        fifo_rst = 1'b0;
  logic [8:0]  exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  dp_linefmt dut (
    .clk      (clk),
    .resetn   (resetn),
    .dphstart (dphstart),
    .dpvstart (dpvstart),
    .hact     (hact),
    .vact     (vact),
    .hdata    (hdata),
    .mvid     (mvid),
    .pxdata   (pxdata),
    .pxvalid  (pxvalid),
    .pxready  (pxready),
    .sym      (sym),
    .vblank   (vblank),
    .underrun (underrun),
    .clrerr   (clrerr)
  );

  always #5 clk = ~clk;

  // pixel FIFO model: pops on each accepted handshake
  assign pxdata = fifo_mem[fifo_idx[3:0]];
  always @(posedge clk) begin
    if (fifo_rst)                fifo_idx <= 0;
    else if (pxvalid && pxready) fifo_idx <= fifo_idx + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic vs);
    dphstart = 1'b1;
    dpvstart = vs;
    tick();
    dphstart = 1'b0;
    dpvstart = 1'b0;
  endtask

  task automatic flush_fifo;
    fifo_rst = 1'b1;
    tick();
    fifo_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;

    // reset state
    #12;
    check_eq("rst sym", 16'(sym), 16'h000);
    check_eq("rst pxready", 16'(pxready), 16'h0);
    check_eq("rst vblank", 16'(vblank), 16'h1);
    check_eq("rst underrun", 16'(underrun), 16'h0);
    resetn = 1'b1;
    tick();

    // dphstart before any dpvstart is ignored
    vact = 16'd2; hact = 16'd3; hdata = 16'd6; mvid = 8'h5A; pxvalid = 1'b1;
    start_line(1'b0);
    check_eq("idle sym p0", 16'(sym), 16'h000);
    repeat (3) tick();
    check_eq("idle sym", 16'(sym), 16'h000);
    check_eq("idle pxready", 16'(pxready), 16'h0);
    check_eq("idle vblank", 16'(vblank), 16'h1);

    // two active lines (yline 0 and 1)
    fifo_mem[0] = 8'h11; fifo_mem[1] = 8'h22; fifo_mem[2] = 8'h33;
    exp_q = '{9'h1BC, 9'h000, 9'h05A, 9'h000, 9'h000, 9'h000,
              9'h1FB, 9'h011, 9'h022, 9'h033, 9'h000, 9'h000};
    for (int ln = 0; ln < 2; ln++) begin
      flush_fifo();
      start_line(ln == 0);
      check_eq($sformatf("act%0d p0", ln), 16'(sym), 16'(exp_q[0]));
      check_eq($sformatf("act%0d vblank", ln), 16'(vblank), 16'h0);
      mvid = 8'hFF;
      for (int p = 1; p < exp_q.size(); p++) begin
        tick();
        check_eq($sformatf("act%0d p%0d", ln, p), 16'(sym), 16'(exp_q[p]));
        if (p == 6) check_eq($sformatf("act%0d pxready", ln), 16'(pxready), 16'h1);
      end
      mvid = 8'h5A;
      check_eq($sformatf("act%0d underrun", ln), 16'(underrun), 16'h0);
      check_eq($sformatf("act%0d popped", ln), 16'(fifo_idx), 16'd3);
    end

    // yline=2 >= vact: blanking line
    exp_q = '{9'h1BC, 9'h001, 9'h05A, 9'h000, 9'h000,
              9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    start_line(1'b0);
    check_eq("vbl p0", 16'(sym), 16'(exp_q[0]));
    check_eq("vbl vblank", 16'(vblank), 16'h1);
    for (int p = 1; p < exp_q.size(); p++) begin
      tick();
      check_eq($sformatf("vbl p%0d", p), 16'(sym), 16'(exp_q[p]));
      check_eq($sformatf("vbl pxready p%0d", p), 16'(pxready), 16'h0);
    end
    check_eq("vbl vblank end", 16'(vblank), 16'h1);

    // underrun on the second data position
    hact = 16'd4;
    fifo_mem[0] = 8'h31; fifo_mem[1] = 8'h42; fifo_mem[2] = 8'h53; fifo_mem[3] = 8'h64;
    flush_fifo();
    exp_q = '{9'h1BC, 9'h000, 9'h05A, 9'h000, 9'h000, 9'h000,
              9'h1FB, 9'h031, 9'h000, 9'h042, 9'h053, 9'h000};
    start_line(1'b1);
    check_eq("ur p0", 16'(sym), 16'(exp_q[0]));
    for (int p = 1; p < exp_q.size(); p++) begin
      tick();
      if (p == 7) pxvalid = 1'b0;
      if (p == 8) pxvalid = 1'b1;
      check_eq($sformatf("ur p%0d", p), 16'(sym), 16'(exp_q[p]));
    end
    check_eq("ur flag", 16'(underrun), 16'h1);
    check_eq("ur popped", 16'(fifo_idx), 16'd3);
    repeat (3) tick();
    check_eq("ur sticky", 16'(underrun), 16'h1);
    clrerr = 1'b1;
    tick();
    clrerr = 1'b0;
    check_eq("ur cleared", 16'(underrun), 16'h0);

    // fresh underrun in the same cycle as clrerr: set wins
    hact = 16'd2;
    pxvalid = 1'b0;
    exp_q = '{9'h1BC, 9'h000, 9'h05A, 9'h000, 9'h000,
              9'h000, 9'h1FB, 9'h000, 9'h000, 9'h000};
    start_line(1'b0);
    for (int p = 1; p < exp_q.size(); p++) begin
      tick();
      if (p == 6) clrerr = 1'b1;
      if (p == 7) begin
        check_eq("prio underrun", 16'(underrun), 16'h1);
        clrerr = 1'b0;
      end
      check_eq($sformatf("prio p%0d", p), 16'(sym), 16'(exp_q[p]));
    end
    check_eq("prio sticky", 16'(underrun), 16'h1);
    clrerr = 1'b1;
    tick();
    clrerr = 1'b0;
    check_eq("prio cleared", 16'(underrun), 16'h0);
    pxvalid = 1'b1;

    // short hdata (BE at p=4) and abort at p=7
    hdata = 16'd1; hact = 16'd8;
    for (int i = 0; i < 8; i++) fifo_mem[i] = 8'h71 + 8'(i);
    flush_fifo();
    exp_q = '{9'h1BC, 9'h000, 9'h05A, 9'h000, 9'h1FB, 9'h071, 9'h072};
    start_line(1'b1);
    for (int p = 1; p < exp_q.size(); p++) begin
      tick();
      check_eq($sformatf("short p%0d", p), 16'(sym), 16'(exp_q[p]));
    end
    dphstart = 1'b1;
    #1;
    check_eq("abort pxready", 16'(pxready), 16'h0);
    tick();
    dphstart = 1'b0;
    check_eq("abort bs", 16'(sym), 16'h1BC);
    check_eq("abort popped", 16'(fifo_idx), 16'd2);

    // async reset in the middle of DATA
    repeat (5) tick();
    check_eq("pre-rst pxready", 16'(pxready), 16'h1);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst sym", 16'(sym), 16'h000);
    check_eq("arst pxready", 16'(pxready), 16'h0);
    check_eq("arst vblank", 16'(vblank), 16'h1);
    #2 resetn = 1'b1;
    start_line(1'b0);
    check_eq("post-rst ignored", 16'(sym), 16'h000);
    tick();
    check_eq("post-rst sym", 16'(sym), 16'h000);
    check_eq("post-rst pxready", 16'(pxready), 16'h0);
    start_line(1'b1);
    check_eq("post-rst bs", 16'(sym), 16'h1BC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
